// File: rtl/gcn_transform_ctrl_if.sv
// Handshake and read/write strobe bundle between the GCN transform
// controller and its memory / dot-product / result-buffer environment.
interface gcn_transform_ctrl_if #(
  parameter int FEATURE_ROWS  = 6,
  parameter int WEIGHT_COLS   = 3,
  parameter int ADDRESS_WIDTH = 13
);
  localparam int ROW_W = (FEATURE_ROWS > 1) ? $clog2(FEATURE_ROWS) : 1;
  localparam int COL_W = (WEIGHT_COLS > 1) ? $clog2(WEIGHT_COLS) : 1;

  logic                     start;
  logic                     mac_done;
  logic [ADDRESS_WIDTH-1:0] read_address;
  logic                     enable_read;
  logic                     weight_load;
  logic                     feature_load;
  logic                     mac_start;
  logic                     wr_en;
  logic [ROW_W-1:0]         wr_row;
  logic [COL_W-1:0]         wr_col;
  logic                     done;

  // Controller side.
  modport master (
    input  start, mac_done,
    output read_address, enable_read, weight_load, feature_load,
           mac_start, wr_en, wr_row, wr_col, done
  );

  // Environment side (host, memory, MAC unit, result buffer).
  modport slave (
    output start, mac_done,
    input  read_address, enable_read, weight_load, feature_load,
           mac_start, wr_en, wr_row, wr_col, done
  );
endinterface

// File: rtl/gcn_transform_ctrl.sv
// Sequencer for one GCN feature x weight transformation: for each weight
// column it loads the column once, then walks every feature row, launching
// a dot product and writing its result to (row, col). All outputs are
// registered and decoded from the next state, so each strobe is high
// exactly while the FSM sits in the state that owns it.
module gcn_transform_ctrl #(
  parameter int FEATURE_ROWS  = 6,
  parameter int WEIGHT_COLS   = 3,
  parameter int ADDRESS_WIDTH = 13,
  parameter int FEATURE_BASE  = 512
) (
  input  logic                  clk,
  input  logic                  reset,
  gcn_transform_ctrl_if.master  bus
);

  localparam int ROW_W = (FEATURE_ROWS > 1) ? $clog2(FEATURE_ROWS) : 1;
  localparam int COL_W = (WEIGHT_COLS > 1) ? $clog2(WEIGHT_COLS) : 1;

  localparam logic [ROW_W-1:0]         ROW_LAST = ROW_W'(FEATURE_ROWS - 1);
  localparam logic [COL_W-1:0]         COL_LAST = COL_W'(WEIGHT_COLS - 1);
  localparam logic [ADDRESS_WIDTH-1:0] FEATURE_BASE_ADDR = ADDRESS_WIDTH'(FEATURE_BASE);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RD_W,
    ST_RD_F,
    ST_MAC,
    ST_WAIT,
    ST_WR,
    ST_DONE
  } state_t;

  state_t           state, next_state;
  logic [ROW_W-1:0] row, next_row;
  logic [COL_W-1:0] col, next_col;

  // Next-state and traversal-counter logic (column-outer, row-inner).
  always_comb begin
    // NOTE: every variable written here gets a default first, so no path leaves it unassigned and no latch is inferred.
    next_state = state;
    next_row   = row;
    next_col   = col;
    unique case (state)
      ST_IDLE: begin
        if (bus.start) begin
          next_state = ST_RD_W;
          next_row   = '0;
          next_col   = '0;
        end
      end
      ST_RD_W: next_state = ST_RD_F;
      ST_RD_F: next_state = ST_MAC;
      ST_MAC:  next_state = ST_WAIT;
      ST_WAIT: begin
        // mac_done is only meaningful here; elsewhere it is ignored.
        if (bus.mac_done) next_state = ST_WR;
      end
      ST_WR: begin
        if (row != ROW_LAST) begin
          next_row   = row + ROW_W'(1);
          next_state = ST_RD_F;
        end else if (col != COL_LAST) begin
          next_row   = '0;
          next_col   = col + COL_W'(1);
          next_state = ST_RD_W;
        end else begin
          next_state = ST_DONE;
        end
      end
      ST_DONE: begin
        if (!bus.start) next_state = ST_IDLE;
      end
      default: next_state = ST_IDLE;
    endcase
  end

  // State and counter registers; reset abandons any run in progress.
  always_ff @(posedge clk or negedge reset) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples the same pre-edge values.
    if (!reset) begin
      state <= ST_IDLE;
      row   <= '0;
      col   <= '0;
    end else begin
      state <= next_state;
      row   <= next_row;
      col   <= next_col;
    end
  end

  // Registered Moore outputs, decoded from the state being entered.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      bus.read_address <= '0;
      bus.enable_read  <= 1'b0;
      bus.weight_load  <= 1'b0;
      bus.feature_load <= 1'b0;
      bus.mac_start    <= 1'b0;
      bus.wr_en        <= 1'b0;
      bus.wr_row       <= '0;
      bus.wr_col       <= '0;
      bus.done         <= 1'b0;
    end else begin
      bus.enable_read  <= (next_state == ST_RD_W) || (next_state == ST_RD_F);
      bus.weight_load  <= (next_state == ST_RD_W);
      bus.feature_load <= (next_state == ST_RD_F);
      bus.mac_start    <= (next_state == ST_MAC);
      bus.wr_en        <= (next_state == ST_WR);
      bus.done         <= (next_state == ST_DONE);

      // The address only moves on a read; otherwise it keeps its last value.
      if (next_state == ST_RD_W) begin
        bus.read_address <= ADDRESS_WIDTH'(next_col);
      end else if (next_state == ST_RD_F) begin
        bus.read_address <= FEATURE_BASE_ADDR + ADDRESS_WIDTH'(next_row);
      end

      if (next_state == ST_WR) begin
        bus.wr_row <= next_row;
        bus.wr_col <= next_col;
      end
    end
  end

endmodule

// File: tb/tb_gcn_transform_ctrl.sv
// Scoreboard bench for gcn_transform_ctrl. Each run pushes the complete
// expected event stream (weight loads, feature loads, MAC launches, result
// writes, done) plus the expected run length into queues; a monitor pops
// and compares whenever the DUT raises a strobe. A responder returns
// mac_done after a per-pair random delay; an optional injector fires
// spurious mac_done pulses during feature reads and DONE.
module tb_gcn_transform_ctrl;

  localparam int FR = 6;
  localparam int WC = 3;
  localparam int AW = 13;
  localparam int FB = 512;
  localparam int NP = FR * WC;

  typedef enum int {EV_WLOAD, EV_FLOAD, EV_MAC, EV_WR, EV_DONE} ev_kind_t;
  typedef struct {
    ev_kind_t kind;
    int       addr;
    int       row;
    int       col;
  } ev_t;

  logic clk;
  logic reset;
  logic resp_done;
  logic spur_done;
  bit   spur_en;

  int   checks_total;
  int   checks_passed;

  ev_t  exp_ev[$];
  int   exp_lat[$];
  int   delays[NP];
  int   resp_idx;

  gcn_transform_ctrl_if #(.FEATURE_ROWS(FR), .WEIGHT_COLS(WC), .ADDRESS_WIDTH(AW)) bus ();

  gcn_transform_ctrl #(
    .FEATURE_ROWS(FR), .WEIGHT_COLS(WC), .ADDRESS_WIDTH(AW), .FEATURE_BASE(FB)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  assign bus.mac_done = resp_done | spur_done;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input int actual, input int expected);
    checks_total++;
    if (actual == expected) checks_passed++;
    else $display("FAIL %s: got %0d, expected %0d at %0t", name, actual, expected, $time);
  endtask

  // Dot-product responder: mac_done arrives delays[i] cycles after mac_start.
  initial begin
    resp_done = 1'b0;
    forever begin
      int d;
      @(negedge clk);
      if (reset && bus.mac_start) begin
        d = delays[resp_idx % NP];
        resp_idx++;
        repeat (d) @(posedge clk);
        #1 resp_done = 1'b1;
        @(posedge clk);
        #1 resp_done = 1'b0;
      end
    end
  end

  // Spurious mac_done injector, active only during feature reads and DONE.
  initial begin
    spur_done = 1'b0;
    forever begin
      @(negedge clk);
      if (spur_en && reset && (bus.feature_load || bus.done) && ($urandom_range(0, 1) == 1)) begin
        spur_done = 1'b1;
        @(posedge clk);
        #1 spur_done = 1'b0;
      end
    end
  end

  // Monitor: compares each observed strobe against the expected stream.
  initial begin
    int  cyc;
    int  run_start;
    int  last_addr;
    int  n;
    bit  in_run;
    bit  prev_done;
    ev_kind_t k;
    ev_t e;
    cyc = 0; run_start = 0; last_addr = 0; in_run = 0; prev_done = 0;
    forever begin
      @(negedge clk);
      cyc++;
      if (!reset) begin
        in_run    = 0;
        last_addr = 0;
        prev_done = 0;
      end else begin
        n = int'(bus.weight_load) + int'(bus.feature_load) + int'(bus.mac_start) + int'(bus.wr_en);
        if (n > 0) begin
          check("strobe_onehot", n, 1);
          if (bus.weight_load)       k = EV_WLOAD;
          else if (bus.feature_load) k = EV_FLOAD;
          else if (bus.mac_start)    k = EV_MAC;
          else                       k = EV_WR;
          if (k == EV_WLOAD && !in_run) begin
            in_run    = 1;
            run_start = cyc;
          end
          if (exp_ev.size() == 0) begin
            check("unexpected_strobe", n, 0);
          end else begin
            e = exp_ev.pop_front();
            check("event_kind", int'(k), int'(e.kind));
            if (e.kind == EV_WLOAD || e.kind == EV_FLOAD) begin
              check("read_enable", int'(bus.enable_read), 1);
              check("read_address", int'(bus.read_address), e.addr);
              last_addr = e.addr;
            end
            if (e.kind == EV_WR) begin
              check("wr_row", int'(bus.wr_row), e.row);
              check("wr_col", int'(bus.wr_col), e.col);
            end
          end
        end
        if (!(bus.weight_load || bus.feature_load)) begin
          check("read_enable_idle", int'(bus.enable_read), 0);
          check("address_hold", int'(bus.read_address), last_addr);
        end
        if (bus.done && !prev_done) begin
          if (exp_ev.size() == 0) begin
            check("unexpected_done", int'(bus.done), 0);
          end else begin
            e = exp_ev.pop_front();
            check("done_order", int'(EV_DONE), int'(e.kind));
          end
          if (exp_lat.size() > 0) check("run_latency", cyc - run_start, exp_lat.pop_front());
          in_run = 0;
        end
        prev_done = bus.done;
      end
    end
  end

  // Builds the expected stream for one run and raises start.
  // mode 0: mac_done one cycle after mac_start; 1: five cycles; 2: random 1..6.
  task automatic begin_run(input int mode, input bit spur);
    int lat;
    lat = WC;
    for (int i = 0; i < NP; i++) begin
      case (mode)
        0:       delays[i] = 1;
        1:       delays[i] = 5;
        default: delays[i] = int'($urandom_range(1, 6));
      endcase
      lat += 3 + delays[i];
    end
    resp_idx = 0;
    for (int c = 0; c < WC; c++) begin
      exp_ev.push_back('{EV_WLOAD, c, 0, c});
      for (int r = 0; r < FR; r++) begin
        exp_ev.push_back('{EV_FLOAD, FB + r, r, c});
        exp_ev.push_back('{EV_MAC, 0, r, c});
        exp_ev.push_back('{EV_WR, 0, r, c});
      end
    end
    exp_ev.push_back('{EV_DONE, 0, 0, 0});
    exp_lat.push_back(lat);
    spur_en = spur;
    @(posedge clk);
    #1 bus.start = 1'b1;
  endtask

  // Optionally drops start mid-run, waits for done, then exercises the
  // done/start handshake back to IDLE.
  task automatic finish_run(input int drop_after, input int hold);
    int waited;
    if (drop_after > 0) begin
      repeat (drop_after) @(posedge clk);
      #1 bus.start = 1'b0;
    end
    waited = 0;
    while (!bus.done && waited < 2000) begin
      @(negedge clk);
      waited++;
    end
    check("done_seen", int'(bus.done), 1);
    if (hold > 0 && drop_after == 0) begin
      for (int i = 0; i < hold; i++) begin
        @(negedge clk);
        check("done_hold", int'(bus.done), 1);
      end
      @(posedge clk);
      #1 bus.start = 1'b0;
      @(negedge clk);
      check("done_until_start_seen", int'(bus.done), 1);
      @(negedge clk);
      check("done_cleared_next", int'(bus.done), 0);
    end else begin
      @(posedge clk);
      #1 bus.start = 1'b0;
      waited = 0;
      do begin
        @(negedge clk);
        waited++;
      end while (bus.done && waited < 4);
      check("done_cleared", int'(bus.done), 0);
    end
    spur_en = 0;
  endtask

  // Global time bound.
  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int seen;
    checks_total  = 0;
    checks_passed = 0;
    spur_en       = 0;
    resp_idx      = 0;
    for (int i = 0; i < NP; i++) delays[i] = 1;
    reset     = 1'b0;
    bus.start = 1'b0;

    // Reset state.
    #23;
    check("rst_read_address", int'(bus.read_address), 0);
    check("rst_enable_read", int'(bus.enable_read), 0);
    check("rst_weight_load", int'(bus.weight_load), 0);
    check("rst_feature_load", int'(bus.feature_load), 0);
    check("rst_mac_start", int'(bus.mac_start), 0);
    check("rst_wr_en", int'(bus.wr_en), 0);
    check("rst_done", int'(bus.done), 0);
    @(posedge clk);
    #1 reset = 1'b1;
    repeat (2) @(posedge clk);

    // Nominal, slow MAC, spurious mac_done with held start.
    begin_run(0, 0); finish_run(0, 0);
    begin_run(1, 0); finish_run(0, 0);
    begin_run(0, 1); finish_run(0, 4);

    // Start dropped mid-run, random MAC latency.
    begin_run(2, 0); finish_run(int'($urandom_range(5, 60)), 0);
    begin_run(2, 1); finish_run(0, 3);

    // Asynchronous reset while waiting on pair (r=3, c=1).
    begin_run(1, 0);
    seen = 0;
    for (int i = 0; i < 2000 && seen < 10; i++) begin
      @(negedge clk);
      if (bus.mac_start) seen++;
    end
    check("reached_pair_r3_c1", seen, 10);
    @(posedge clk);
    #3 reset = 1'b0;
    #1;
    check("async_rst_read_address", int'(bus.read_address), 0);
    check("async_rst_enable_read", int'(bus.enable_read), 0);
    check("async_rst_weight_load", int'(bus.weight_load), 0);
    check("async_rst_feature_load", int'(bus.feature_load), 0);
    check("async_rst_mac_start", int'(bus.mac_start), 0);
    check("async_rst_wr_en", int'(bus.wr_en), 0);
    check("async_rst_wr_row", int'(bus.wr_row), 0);
    check("async_rst_wr_col", int'(bus.wr_col), 0);
    check("async_rst_done", int'(bus.done), 0);
    exp_ev.delete();
    exp_lat.delete();
    bus.start = 1'b0;
    repeat (8) @(posedge clk);
    #1 reset = 1'b1;
    begin_run(0, 0); finish_run(0, 0);

    // A few more randomized runs.
    for (int i = 0; i < 3; i++) begin
      begin_run(2, 1);
      if (($urandom_range(0, 1)) == 1) finish_run(int'($urandom_range(5, 60)), 0);
      else finish_run(0, int'($urandom_range(1, 4)));
    end

    repeat (3) @(negedge clk);
    check("leftover_events", exp_ev.size(), 0);
    $display("%0d/%0d checks passed", checks_passed, checks_total);
    $finish;
  end

endmodule

// File: doc/gcn_transform_ctrl.md
GCN_TRANSFORM_CTRL -- requirements
Module: gcn_transform_ctrl

Interface
REQ-001 Parameter FEATURE_ROWS, default 6: number of feature-matrix rows (graph nodes).
REQ-002 Parameter WEIGHT_COLS, default 3: number of weight-matrix columns.
REQ-003 Parameter ADDRESS_WIDTH, default 13: width of the shared read address.
REQ-004 Parameter FEATURE_BASE, default 512: first read address of the feature memory region; weight column c lives at address c.
REQ-005 clk  input  1  single clock; all state changes on the rising edge.
REQ-006 reset  input  1  asynchronous, active-low reset.
REQ-007 start  input  1  level request to run one full feature x weight transformation.
REQ-008 mac_done  input  1  one-cycle pulse from the dot-product unit when a result is valid.
REQ-009 read_address  output  ADDRESS_WIDTH  address to the shared weight/feature read port.
REQ-010 enable_read  output  1  read strobe; memory data is valid in the same cycle.
REQ-011 weight_load  output  1  latch data_in into the weight vector register.
REQ-012 feature_load  output  1  latch data_in into the feature vector register.
REQ-013 mac_start  output  1  one-cycle pulse launching a dot product.
REQ-014 wr_en  output  1  write the dot-product result into the result buffer.
REQ-015 wr_row  output  $clog2(FEATURE_ROWS)  result-buffer row index for wr_en.
REQ-016 wr_col  output  $clog2(WEIGHT_COLS)  result-buffer column index for wr_en.
REQ-017 done  output  1  all FEATURE_ROWS x WEIGHT_COLS results written.

Function
REQ-018 The FSM SHALL have the states IDLE, RD_W, RD_F, MAC, WAIT, WR and DONE.
REQ-019 IDLE: all strobes low; start=1 SHALL move the FSM to RD_W with col=0 and row=0.
REQ-020 RD_W (1 cycle): enable_read=1, read_address=col, weight_load=1; next state RD_F.
REQ-021 RD_F (1 cycle): enable_read=1, read_address=FEATURE_BASE+row, feature_load=1; next state MAC.
REQ-022 MAC (1 cycle): mac_start=1; next state WAIT.
REQ-023 WAIT: all strobes low; the state SHALL be held until mac_done=1 is sampled, then move to WR.
REQ-024 WR (1 cycle): wr_en=1, wr_row=row, wr_col=col.
REQ-025 After WR, if row<FEATURE_ROWS-1, row SHALL be incremented and the FSM SHALL go to RD_F.
REQ-026 After WR, if row=FEATURE_ROWS-1 and col<WEIGHT_COLS-1, row SHALL clear, col SHALL increment and the FSM SHALL go to RD_W.
REQ-027 After WR with row=FEATURE_ROWS-1 and col=WEIGHT_COLS-1, the FSM SHALL go to DONE.
REQ-028 Traversal order SHALL be column-outer, row-inner; each weight column is read exactly once per run.
REQ-029 DONE: done=1; done SHALL hold while start=1, and start=0 SHALL return the FSM to IDLE, clearing done.
REQ-030 start SHALL be ignored in every state except IDLE; deasserting start mid-run SHALL NOT abort the run.
REQ-031 A mac_done arriving outside WAIT SHALL be ignored, with no state or counter change.
REQ-032 At most one of weight_load, feature_load, mac_start and wr_en SHALL be high in any cycle.
REQ-033 When enable_read=0, read_address SHALL hold its last value (no X, no glitch to zero).
REQ-034 All outputs SHALL be registered (Moore); strobes SHALL be high only in their listed state.
REQ-035 Counters SHALL never exceed FEATURE_ROWS-1 or WEIGHT_COLS-1; there is no wrap past a terminal count.

Reset
REQ-036 reset=0 SHALL force IDLE immediately, regardless of clk.
REQ-037 reset=0 SHALL clear row, col, read_address, enable_read, weight_load, feature_load, mac_start, wr_en, wr_row, wr_col and done to 0.
REQ-038 Reset asserted mid-run SHALL abandon the run; after release, a new run needs start=1 seen in IDLE.

Verification
REQ-039 Nominal: reset released, start=1, mac_done returned in the cycle after mac_start -> done rises 75 cycles after the first RD_W; 18 wr_en pulses in order (r,c) = (0,0)..(5,0),(0,1)..(5,2).
REQ-040 Addresses: same run -> read_address sequence 0,512..517,1,512..517,2,512..517, with exactly 3 weight_load and 18 feature_load pulses.
REQ-041 Slow MAC: mac_done delayed 5 cycles after mac_start for every pair -> FSM holds in WAIT; total 3*(1+6*8)=147 cycles; no extra strobes.
REQ-042 Spurious mac_done: pulse during RD_F and DONE -> no wr_en, counters unchanged, final results identical to nominal.
REQ-043 Reset mid-op: reset=0 asynchronously during WAIT at (r=3,c=1) -> all outputs 0 without waiting for a clock edge; after release with start=1, the sequence restarts at address 0.
REQ-044 Handshake: start dropped mid-run -> run completes; start held after done -> done stays 1; start=0 -> IDLE and done=0 next cycle.
